// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader, CPU and instruction memory.
// Holds the loader state encoding, width defaults and reserved-bit helpers.
package imem_loader_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int INST_W_DEF = 19;

    // Bits of the third word byte that must be zero in a valid image.
    localparam logic [7:0] RSVD_MASK = 8'hF8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        B0   = 3'd2,
        B1   = 3'd3,
        B2   = 3'd4,
        CSUM = 3'd5,
        DONE = 3'd6,
        ERR  = 3'd7
    } state_t;

    function automatic logic rsvd_bad(input logic [7:0] byte2);
        return |(byte2 & RSVD_MASK);
    endfunction

endpackage

// File: rtl/imem_word_asm.sv
// Byte shift register and instruction-word assembly for the loader.
// The third byte is taken straight from the stream so the word is ready on its transfer.
module imem_word_asm
    import imem_loader_pkg::*;
#(
    parameter int INST_W = INST_W_DEF
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              shift_en,
    input  logic [7:0]        in_data,
    output logic [INST_W-1:0] word,
    output logic              rsvd_err
);

    logic [15:0] shreg_r;

    // Shift each accepted low byte in from the top: after two shifts {byte1, byte0}.
    always_ff @(posedge clk) begin
        if (!reset) begin
            shreg_r <= 16'h0000;
        end else if (shift_en) begin
            shreg_r <= {in_data, shreg_r[15:8]};
        end else begin
            shreg_r <= shreg_r;
        end
    end

    assign word     = {in_data[INST_W-17:0], shreg_r};
    assign rsvd_err = rsvd_bad(in_data);

endmodule

// File: rtl/imem_loader.sv
// Loads the instruction memory from a header+payload byte stream and holds the CPU in reset meanwhile.
// Optional trailer checksum check is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int INST_W    = INST_W_DEF,
    parameter int BASE_ADDR = 0
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [INST_W-1:0] imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    localparam int                LEFT_W     = ((ADDR_W > 8) ? ADDR_W : 8) + 1;
    localparam logic [ADDR_W-1:0] BASE       = ADDR_W'(BASE_ADDR);
    localparam logic [LEFT_W-1:0] FULL_COUNT = LEFT_W'(1'b1) << ADDR_W;

    state_t              state_r;
    state_t              next_s;
    logic                accept_s;
    logic                write_s;
    logic                last_word_s;
    logic                shift_en_s;
    logic                rsvd_err_s;
    logic [INST_W-1:0]   word_s;
    logic [LEFT_W-1:0]   words_left_r;
    logic [ADDR_W-1:0]   next_addr_r;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]          csum_r;
`endif

    assign accept_s    = in_valid && in_ready;
    assign last_word_s = (words_left_r == LEFT_W'(1'b1));
    assign shift_en_s  = accept_s && ((state_r == B0) || (state_r == B1));
    assign write_s     = accept_s && (state_r == B2) && !rsvd_err_s;

    imem_word_asm #(
        .INST_W (INST_W)
    ) u_word_asm (
        .clk      (clk),
        .reset    (reset),
        .shift_en (shift_en_s),
        .in_data  (in_data),
        .word     (word_s),
        .rsvd_err (rsvd_err_s)
    );

    // Next-state logic for the load sequence.
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE, DONE, ERR: begin
                if (start) next_s = HDR;
                else       next_s = state_r;
            end
            HDR: begin
                if (accept_s) next_s = B0;
                else          next_s = state_r;
            end
            B0: begin
                if (accept_s) next_s = B1;
                else          next_s = state_r;
            end
            B1: begin
                if (accept_s) next_s = B2;
                else          next_s = state_r;
            end
            B2: begin
                if (!accept_s)       next_s = state_r;
                else if (rsvd_err_s) next_s = ERR;
`ifdef IMEM_LOADER_CHECKSUM_EN
                else if (last_word_s) next_s = CSUM;
`else
                else if (last_word_s) next_s = DONE;
`endif
                else                 next_s = B0;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM: begin
                if (!accept_s)              next_s = state_r;
                else if (in_data == csum_r) next_s = DONE;
                else                        next_s = ERR;
            end
`endif
            default: next_s = IDLE;
        endcase
    end

    // State register and status outputs, registered from the next state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r  <= IDLE;
            in_ready <= 1'b0;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            state_r  <= next_s;
            in_ready <= (next_s == HDR) || (next_s == B0) || (next_s == B1) ||
                        (next_s == B2) || (next_s == CSUM);
            cpu_hold <= (next_s != DONE);
            done     <= (next_s == DONE);
            error    <= (next_s == ERR);
        end
    end

    // Write port: a one-cycle pulse per word; address and data hold afterwards.
    always_ff @(posedge clk) begin
        if (!reset) begin
            imem_we    <= 1'b0;
            imem_addr  <= BASE;
            imem_wdata <= {INST_W{1'b0}};
        end else if (write_s) begin
            imem_we    <= 1'b1;
            imem_addr  <= next_addr_r;
            imem_wdata <= word_s;
        end else begin
            imem_we    <= 1'b0;
            imem_addr  <= imem_addr;
            imem_wdata <= imem_wdata;
        end
    end

    // Word counter and write pointer; header value 0 stands for a full memory image.
    always_ff @(posedge clk) begin
        if (!reset) begin
            words_left_r <= {LEFT_W{1'b0}};
            next_addr_r  <= BASE;
        end else if (accept_s && (state_r == HDR)) begin
            words_left_r <= (in_data == 8'h00) ? FULL_COUNT : {{(LEFT_W-8){1'b0}}, in_data};
            next_addr_r  <= BASE;
        end else if (write_s) begin
            words_left_r <= words_left_r - LEFT_W'(1'b1);
            next_addr_r  <= next_addr_r + ADDR_W'(1'b1);
        end else begin
            words_left_r <= words_left_r;
            next_addr_r  <= next_addr_r;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Running XOR of the header and every payload byte.
    always_ff @(posedge clk) begin
        if (!reset) begin
            csum_r <= 8'h00;
        end else if (accept_s && (state_r == HDR)) begin
            csum_r <= in_data;
        end else if (accept_s) begin
            csum_r <= csum_r ^ in_data;
        end else begin
            csum_r <= csum_r;
        end
    end
`endif

endmodule
